// File: rtl/load_align_unit.sv
// In-order load queue that pairs issued loads with memory responses, then lane-selects and
// extends the data. Define LOAD_ALIGN_LWLR_EN to enable the LWL/LWR merge with a stored rt.
module load_align_unit #(
    parameter int unsigned BUS_W = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_rt,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             mem_rvalid,
    input  logic [BUS_W-1:0] mem_rdata,
    input  logic             flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag
);
    localparam int unsigned AddrW = $clog2(BUS_W / 8);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam logic [31:0] BadOp = 32'h1234abcd;

    logic [3:0]       op_q   [DEPTH];
    logic [AddrW-1:0] addr_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [BUS_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] got_q, got_d, killed_q, killed_d;

    logic [PtrW-1:0]  alloc_ptr_q, alloc_ptr_d, rsp_ptr_q, rsp_ptr_d, head_ptr_q, head_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d, wait_q, wait_d;

    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

    logic             alloc, rsp_accept, head_bypass, head_avail, head_kill, out_load, pop;
    logic [BUS_W-1:0] head_raw;
    logic [AddrW-1:0] head_addr;
    logic [3:0]       head_op;
    logic [31:0]      word, result;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [1:0]       n;

    logic unused_addr;
    assign unused_addr = ^req_addr[31:AddrW];

`ifdef LOAD_ALIGN_LWLR_EN
    logic [31:0] rt_q [DEPTH];
    logic [31:0] head_rt;
    assign head_rt = rt_q[head_ptr_q];
`else
    logic unused_rt;
    assign unused_rt = ^req_rt;
`endif

    assign req_ready   = (cnt_q != CntW'(DEPTH));
    assign alloc       = req_valid && req_ready;
    // Responses with nothing outstanding are dropped so the queue state stays consistent.
    assign rsp_accept  = mem_rvalid && (wait_q != '0);
    assign head_bypass = rsp_accept && (rsp_ptr_q == head_ptr_q);
    assign head_avail  = (cnt_q != '0) && (got_q[head_ptr_q] || head_bypass);
    // Every entry present during a flush cycle is older than the flush, so treat it as killed.
    assign head_kill   = killed_q[head_ptr_q] || flush;
    assign out_load    = head_avail && !head_kill && (!wb_valid_q || wb_ready);
    assign pop         = head_avail && (out_load || head_kill);

    assign head_raw  = got_q[head_ptr_q] ? data_q[head_ptr_q] : mem_rdata;
    assign head_addr = addr_q[head_ptr_q];
    assign head_op   = op_q[head_ptr_q];

    generate
        if (BUS_W == 64) begin : g_lane64
            assign word = head_addr[2] ? head_raw[63:32] : head_raw[31:0];
        end else begin : g_lane32
            assign word = head_raw[31:0];
        end
    endgenerate

    always_comb begin
        n        = head_addr[1:0];
        byte_sel = word[{n, 3'b000} +: 8];
        half_sel = word[{n[1], 4'b0000} +: 16];
        result   = BadOp;
        case (head_op)
            4'b0000: result = word;
            4'b0001: result = {24'h0, byte_sel};
            4'b0010: result = {{24{byte_sel[7]}}, byte_sel};
            4'b0011: result = {16'h0, half_sel};
            4'b0100: result = {{16{half_sel[15]}}, half_sel};
`ifdef LOAD_ALIGN_LWLR_EN
            4'b0101: begin
                case (n)
                    2'd0:    result = {word[7:0], head_rt[23:0]};
                    2'd1:    result = {word[15:0], head_rt[15:0]};
                    2'd2:    result = {word[23:0], head_rt[7:0]};
                    default: result = word;
                endcase
            end
            4'b0110: begin
                case (n)
                    2'd0:    result = word;
                    2'd1:    result = {head_rt[31:24], word[31:8]};
                    2'd2:    result = {head_rt[31:16], word[31:16]};
                    default: result = {head_rt[31:8], word[31:24]};
                endcase
            end
`endif
            default: result = BadOp;
        endcase
    end

    always_comb begin
        alloc_ptr_d = alloc_ptr_q + PtrW'(alloc);
        rsp_ptr_d   = rsp_ptr_q + PtrW'(rsp_accept);
        head_ptr_d  = head_ptr_q + PtrW'(pop);
        cnt_d       = cnt_q + CntW'(alloc) - CntW'(pop);
        wait_d      = wait_q + CntW'(alloc) - CntW'(rsp_accept);

        got_d    = got_q;
        killed_d = killed_q;
        if (flush) begin
            killed_d = '1;
        end
        if (rsp_accept) begin
            got_d[rsp_ptr_q] = 1'b1;
        end
        // A freshly allocated entry is never killed by the flush of its own cycle.
        if (alloc) begin
            got_d[alloc_ptr_q]    = 1'b0;
            killed_d[alloc_ptr_q] = 1'b0;
        end

        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (out_load) begin
            wb_valid_d = 1'b1;
        end else if (wb_ready) begin
            wb_valid_d = 1'b0;
        end
        if (out_load) begin
            wb_data_d = result;
            wb_tag_d  = tag_q[head_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alloc_ptr_q <= '0;
            rsp_ptr_q   <= '0;
            head_ptr_q  <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            got_q       <= '0;
            killed_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_tag_q    <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            rsp_ptr_q   <= rsp_ptr_d;
            head_ptr_q  <= head_ptr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            got_q       <= got_d;
            killed_q    <= killed_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_tag_q    <= wb_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            op_q[alloc_ptr_q]   <= req_op;
            addr_q[alloc_ptr_q] <= req_addr[AddrW-1:0];
            tag_q[alloc_ptr_q]  <= req_tag;
`ifdef LOAD_ALIGN_LWLR_EN
            rt_q[alloc_ptr_q]   <= req_rt;
`endif
        end
        if (rsp_accept) begin
            data_q[rsp_ptr_q] <= mem_rdata;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_tag   = wb_tag_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a 32-bit-bus instance for queue, flush and reset
// behaviour and a 64-bit-bus instance for lane selection.
module tb_load_align_unit;
    logic        clk;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_rt;
    logic [4:0]  req_tag;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;

    logic        req_valid64, req_ready64;
    logic [3:0]  req_op64;
    logic [31:0] req_addr64;
    logic [4:0]  req_tag64;
    logic        mem_rvalid64;
    logic [63:0] mem_rdata64;
    logic        wb_valid64, wb_ready64;
    logic [31:0] wb_data64;
    logic [4:0]  wb_tag64;

    int checks = 0;
    int errors = 0;
    bit seen;

    load_align_unit #(.BUS_W(32), .DEPTH(4), .TAG_W(5)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_rt(req_rt), .req_tag(req_tag),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag)
    );

    load_align_unit #(.BUS_W(64), .DEPTH(4), .TAG_W(5)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_op(req_op64),
        .req_addr(req_addr64), .req_rt(req_rt), .req_tag(req_tag64),
        .mem_rvalid(mem_rvalid64), .mem_rdata(mem_rdata64), .flush(flush),
        .wb_valid(wb_valid64), .wb_ready(wb_ready64), .wb_data(wb_data64), .wb_tag(wb_tag64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rt    = rt;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic run64(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] tag,
                         input logic [63:0] data);
        req_valid64 = 1'b1;
        req_op64    = op;
        req_addr64  = addr;
        req_tag64   = tag;
        tick();
        req_valid64  = 1'b0;
        mem_rvalid64 = 1'b1;
        mem_rdata64  = data;
        tick();
        mem_rvalid64 = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_rt = '0; req_tag = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0; wb_ready = 1'b0;
        req_valid64 = 1'b0; req_op64 = '0; req_addr64 = '0; req_tag64 = '0;
        mem_rvalid64 = 1'b0; mem_rdata64 = '0; wb_ready64 = 1'b0;
        tick();
        tick();
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_tag", {27'd0, wb_tag}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_req_ready64", {31'd0, req_ready64}, 32'd1);
        resetn   = 1'b1;
        wb_ready = 1'b1;
        wb_ready64 = 1'b1;

        // LB / LBU on byte 3
        issue(4'b0010, 32'h0000_0103, 32'h0, 5'd7);
        chk("lb_pre_valid", {31'd0, wb_valid}, 32'd0);
        respond(32'h80AB_CD12);
        chk("lb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_tag", {27'd0, wb_tag}, 32'd7);
        tick();
        chk("lb_retired", {31'd0, wb_valid}, 32'd0);
        issue(4'b0001, 32'h0000_0103, 32'h0, 5'd8);
        respond(32'h80AB_CD12);
        chk("lbu_data", wb_data, 32'h0000_0080);
        chk("lbu_tag", {27'd0, wb_tag}, 32'd8);
        tick();

        // 64-bit lane selection
        run64(4'b0100, 32'h0000_0006, 5'd3, 64'h8001_0000_0000_0000);
        chk("lh64_valid", {31'd0, wb_valid64}, 32'd1);
        chk("lh64_data", wb_data64, 32'hFFFF_8001);
        chk("lh64_tag", {27'd0, wb_tag64}, 32'd3);
        run64(4'b0001, 32'h0000_0001, 5'd4, 64'h0000_0000_0000_AB00);
        chk("lbu64_data", wb_data64, 32'h0000_00AB);
        run64(4'b0000, 32'h0000_0004, 5'd5, 64'h1111_2222_3333_4444);
        chk("lw64_hi_data", wb_data64, 32'h1111_2222);

        // Fill the queue with writeback stalled, then drain in order
        wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(4'b0000, 32'h0, 32'h0, 5'(i));
        end
        chk("full_req_ready", {31'd0, req_ready}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            respond(32'h1000_0000 + 32'(i));
        end
        chk("stall_valid", {31'd0, wb_valid}, 32'd1);
        chk("stall_tag", {27'd0, wb_tag}, 32'd1);
        chk("stall_data", wb_data, 32'h1000_0001);
        chk("stall_req_ready", {31'd0, req_ready}, 32'd1);
        wb_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain_valid", {31'd0, wb_valid}, 32'd1);
            chk("drain_tag", {27'd0, wb_tag}, 32'(i));
            chk("drain_data", wb_data, 32'h1000_0000 + 32'(i));
        end
        tick();
        chk("drain_done", {31'd0, wb_valid}, 32'd0);

        // LWL / LWR merge and an undefined op
        issue(4'b0101, 32'h1, 32'h1122_3344, 5'd9);
        issue(4'b0110, 32'h2, 32'h1122_3344, 5'd10);
        respond(32'hAABB_CCDD);
        chk("lwl_tag", {27'd0, wb_tag}, 32'd9);
`ifdef LOAD_ALIGN_LWLR_EN
        chk("lwl_data", wb_data, 32'hCCDD_3344);
`else
        chk("lwl_data", wb_data, 32'h1234_abcd);
`endif
        respond(32'hAABB_CCDD);
        chk("lwr_tag", {27'd0, wb_tag}, 32'd10);
`ifdef LOAD_ALIGN_LWLR_EN
        chk("lwr_data", wb_data, 32'h1122_AABB);
`else
        chk("lwr_data", wb_data, 32'h1234_abcd);
`endif
        issue(4'b1111, 32'h0, 32'h0, 5'd11);
        respond(32'h0);
        chk("badop_data", wb_data, 32'h1234_abcd);
        tick();

        // Flush drops a result held on a stalled output
        wb_ready = 1'b0;
        issue(4'b0000, 32'h0, 32'h0, 5'd15);
        respond(32'h5555_AAAA);
        chk("held_valid", {31'd0, wb_valid}, 32'd1);
        chk("held_tag", {27'd0, wb_tag}, 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_clears_valid", {31'd0, wb_valid}, 32'd0);
        wb_ready = 1'b1;

        // Flush with three outstanding loads, a new request and a response in the same cycle
        issue(4'b0000, 32'h0, 32'h0, 5'd11);
        issue(4'b0000, 32'h0, 32'h0, 5'd12);
        issue(4'b0000, 32'h0, 32'h0, 5'd13);
        flush      = 1'b1;
        req_valid  = 1'b1; req_op = 4'b0000; req_addr = 32'h0; req_tag = 5'd14;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0001;
        tick();
        flush = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b0;
        chk("flush_cycle_valid", {31'd0, wb_valid}, 32'd0);
        respond(32'hDEAD_0002);
        chk("killed_12_valid", {31'd0, wb_valid}, 32'd0);
        respond(32'hDEAD_0003);
        chk("killed_13_valid", {31'd0, wb_valid}, 32'd0);
        respond(32'hCAFE_0014);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wb_valid) begin
                chk("post_flush_tag", {27'd0, wb_tag}, 32'd14);
                chk("post_flush_data", wb_data, 32'hCAFE_0014);
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("post_flush_seen", {31'd0, seen}, 32'd1);
        tick();
        chk("post_flush_idle", {31'd0, wb_valid}, 32'd0);
        chk("post_flush_ready", {31'd0, req_ready}, 32'd1);

        // Asynchronous reset mid-stream
        wb_ready = 1'b0;
        issue(4'b0000, 32'h0, 32'h0, 5'd16);
        issue(4'b0000, 32'h0, 32'h0, 5'd17);
        respond(32'h7777_0016);
        chk("pre_reset_valid", {31'd0, wb_valid}, 32'd1);
        chk("pre_reset_tag", {27'd0, wb_tag}, 32'd16);
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_rst_tag", {27'd0, wb_tag}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        tick();
        resetn   = 1'b1;
        wb_ready = 1'b1;
        respond(32'h0BAD_0BAD);
        chk("stray_rsp_valid", {31'd0, wb_valid}, 32'd0);
        issue(4'b0011, 32'h2, 32'h0, 5'd18);
        respond(32'hAABB_CCDD);
        chk("after_rst_valid", {31'd0, wb_valid}, 32'd1);
        chk("after_rst_data", wb_data, 32'h0000_AABB);
        chk("after_rst_tag", {27'd0, wb_tag}, 32'd18);
        tick();
        chk("after_rst_idle", {31'd0, wb_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
